interrupt_controller: RTL and testbench

- Consumes the timer's TimerInterrupt line and up to NUM_SRC-1 other level interrupt sources.
- Edge-latches each source into a sticky pending register and masks it with a software enable register.
- Presents one prioritised interrupt request, with cause index, to the pipeline's exception logic.
- Memory-mapped on the same data bus as the timer, using the same address/data/MemRead/MemWrite/tri-state read convention.

---
 rtl/interrupt_controller_pkg.sv | 22 ++
 rtl/interrupt_controller_priority_encoder.sv | 30 +++
 rtl/interrupt_controller.sv | 156 +++++++++++++++
 tb/tb_interrupt_controller.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_controller_pkg.sv
// ============================================================================
// interrupt_controller_pkg : register map and FSM state type for the
// interrupt controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package interrupt_controller_pkg;

    localparam logic [63:0] INTC_PEND_ADDR = 64'h0000_0000_0000_1000;
    localparam logic [63:0] INTC_MASK_ADDR = 64'h0000_0000_0000_1008;
    localparam logic [63:0] INTC_CTRL_ADDR = 64'h0000_0000_0000_1010;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } intc_state_t;

endpackage

`default_nettype wire

// File: rtl/interrupt_controller_priority_encoder.sv
// ============================================================================
// priority_encoder : combinational, lowest set index wins; outputs index+valid.
// Revision: 1.0
// ============================================================================
`default_nettype none

module priority_encoder #(
    parameter int N = 8,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);

    // Scan high-to-low so the last match, the lowest index, is the one kept.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/interrupt_controller.sv
// ============================================================================
// interrupt_controller : edge-latched, masked, prioritised interrupt requests
// on the timer's data bus. Optional macro INTC_SYNC_EN adds 2-flop source syncs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int width   = 64,
    parameter int NUM_SRC = 8,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [width-1:0]   address,
    input  logic [width-1:0]   data,
    input  logic               MemRead,
    input  logic               MemWrite,
    output logic [width-1:0]   rdata,
    output logic               IntcAddress,
    output logic               InterruptRequest,
    output logic [ID_W-1:0]    InterruptCause,
    input  logic               InterruptTaken,
    input  logic               Eret
);

    logic [NUM_SRC-1:0] src_in;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic               gie_q, gie_d;
    intc_state_t        state_q, state_d;
    logic [ID_W-1:0]    cause_q, cause_d;
    logic [NUM_SRC-1:0] active;
    logic [ID_W-1:0]    act_idx;
    logic               act_valid;
    logic               hit_pend, hit_mask, hit_ctrl;
    logic [NUM_SRC-1:0] wdata_src;
    logic [width-1:0]   rd_val;
    logic               in_service;
    logic               unused_data;

`ifdef INTC_SYNC_EN
    logic [NUM_SRC-1:0] sync1_q, sync2_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src;
            sync2_q <= sync1_q;
        end
    end

    assign src_in = sync2_q;
`else
    assign src_in = irq_src;
`endif

    assign rise      = src_in & ~src_q;
    assign hit_pend  = (address == width'(INTC_PEND_ADDR));
    assign hit_mask  = (address == width'(INTC_MASK_ADDR));
    assign hit_ctrl  = (address == width'(INTC_CTRL_ADDR));
    assign wdata_src = data[NUM_SRC-1:0];
    assign unused_data = ^data;

    // A new edge in the same cycle as a W1C of that bit keeps the bit set.
    always_comb begin
        pend_d = pend_q;
        if (MemWrite && hit_pend) begin
            pend_d = pend_d & ~wdata_src;
        end
        pend_d = pend_d | rise;
        mask_d = (MemWrite && hit_mask) ? wdata_src : mask_q;
        gie_d  = (MemWrite && hit_ctrl) ? data[0] : gie_q;
    end

    assign active = pend_q & mask_q;

    priority_encoder #(
        .N (NUM_SRC),
        .W (ID_W)
    ) u_prio (
        .req_i   (active),
        .idx_o   (act_idx),
        .valid_o (act_valid)
    );

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            IDLE: begin
                if (gie_q && act_valid) begin
                    state_d = REQ;
                    cause_d = act_idx;
                end
            end
            REQ: begin
                if (InterruptTaken) begin
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (Eret) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            src_q   <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            gie_q   <= 1'b0;
            state_q <= IDLE;
            cause_q <= '0;
        end else begin
            src_q   <= src_in;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            gie_q   <= gie_d;
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    assign in_service       = (state_q == SERVICE);
    assign InterruptRequest = (state_q == REQ);
    assign InterruptCause   = cause_q;
    assign IntcAddress      = hit_pend | hit_mask | hit_ctrl;

    always_comb begin
        rd_val = '0;
        if (hit_pend) begin
            rd_val[NUM_SRC-1:0] = pend_q;
        end else if (hit_mask) begin
            rd_val[NUM_SRC-1:0] = mask_q;
        end else if (hit_ctrl) begin
            rd_val[1:0] = {in_service, gie_q};
        end
    end

    assign rdata = (MemRead && IntcAddress) ? rd_val : 'z;

endmodule

`default_nettype wire

// File: tb/tb_interrupt_controller.sv
// ============================================================================
// tb_interrupt_controller : directed scoreboard bench for interrupt_controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_interrupt_controller;
    import interrupt_controller_pkg::*;

`ifdef INTC_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    localparam int K_RD   = 0;
    localparam int K_IRQ  = 1;
    localparam int K_Z    = 2;
    localparam int K_ADDR = 3;
    localparam logic [63:0] UNMAPPED = 64'h0000_0000_0000_2000;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  irq_src;
    logic [63:0] address;
    logic [63:0] data;
    logic        MemRead;
    logic        MemWrite;
    wire  [63:0] rdata;
    logic        IntcAddress;
    logic        InterruptRequest;
    logic [2:0]  InterruptCause;
    logic        InterruptTaken;
    logic        Eret;
    logic        probe;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          kind;
        logic [63:0] exp;
        string       name;
    } chk_t;

    chk_t sb[$];
    chk_t c;

    interrupt_controller #(
        .width   (64),
        .NUM_SRC (8),
        .ID_W    (3)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .irq_src          (irq_src),
        .address          (address),
        .data             (data),
        .MemRead          (MemRead),
        .MemWrite         (MemWrite),
        .rdata            (rdata),
        .IntcAddress      (IntcAddress),
        .InterruptRequest (InterruptRequest),
        .InterruptCause   (InterruptCause),
        .InterruptTaken   (InterruptTaken),
        .Eret             (Eret)
    );

    always #5 clock = ~clock;

    // Monitor: one scoreboard entry is consumed per presented cycle.
    always @(negedge clock) begin
        logic [63:0] got;
        if (MemRead || probe) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: got an output cycle, required a queued expectation");
            end else begin
                c = sb.pop_front();
                case (c.kind)
                    K_RD: begin
                        if (rdata !== c.exp) begin
                            errors++;
                            $display("FAIL %s: rdata got %h required %h", c.name, rdata, c.exp);
                        end
                    end
                    K_IRQ: begin
                        got = {48'b0, 8'(InterruptCause), 7'b0, InterruptRequest};
                        if ((c.exp[0] && got !== c.exp) || (!c.exp[0] && got[0] !== 1'b0)) begin
                            errors++;
                            $display("FAIL %s: req/cause got %0b/%0d required %0b/%0d",
                                     c.name, got[0], got[15:8], c.exp[0], c.exp[15:8]);
                        end
                    end
                    K_Z: begin
                        if (rdata !== 64'bz) begin
                            errors++;
                            $display("FAIL %s: rdata got %h required z", c.name, rdata);
                        end
                    end
                    default: begin
                        if (IntcAddress !== c.exp[0]) begin
                            errors++;
                            $display("FAIL %s: IntcAddress got %b required %b", c.name, IntcAddress, c.exp[0]);
                        end
                    end
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input int k, input logic [63:0] e, input string n);
        chk_t t;
        t.kind = k;
        t.exp  = e;
        t.name = n;
        sb.push_back(t);
    endtask

    task automatic bus_write(input logic [63:0] a, input logic [63:0] d);
        address  = a;
        data     = d;
        MemWrite = 1'b1;
        tick();
        MemWrite = 1'b0;
    endtask

    task automatic bus_read(input logic [63:0] a, input logic [63:0] e, input string n);
        push(K_RD, e, n);
        address = a;
        MemRead = 1'b1;
        tick();
        MemRead = 1'b0;
    endtask

    task automatic expect_irq(input logic req, input int cause, input string n);
        push(K_IRQ, {48'b0, 8'(cause), 7'b0, req}, n);
        probe = 1'b1;
        tick();
        probe = 1'b0;
    endtask

    task automatic idle(input int cnt, input string n);
        repeat (cnt) expect_irq(1'b0, 0, n);
    endtask

    task automatic expect_z(input logic [63:0] a, input logic rd, input string n);
        push(K_Z, 64'd0, n);
        address = a;
        MemRead = rd;
        probe   = 1'b1;
        tick();
        probe   = 1'b0;
        MemRead = 1'b0;
    endtask

    task automatic expect_addr(input logic [63:0] a, input logic e, input string n);
        push(K_ADDR, {63'd0, e}, n);
        address = a;
        probe   = 1'b1;
        tick();
        probe   = 1'b0;
    endtask

    task automatic pulse_taken();
        InterruptTaken = 1'b1;
        tick();
        InterruptTaken = 1'b0;
    endtask

    task automatic pulse_eret();
        Eret = 1'b1;
        tick();
        Eret = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; irq_src = '0; address = '0; data = '0;
        MemRead = 1'b0; MemWrite = 1'b0; InterruptTaken = 1'b0; Eret = 1'b0; probe = 1'b0;
        repeat (3) tick();
        expect_irq(1'b0, 0, "rst_irq");
        reset = 1'b0;
        tick();
        bus_read(INTC_PEND_ADDR, 64'h0, "rst_pend");
        bus_read(INTC_MASK_ADDR, 64'h0, "rst_mask");
        bus_read(INTC_CTRL_ADDR, 64'h0, "rst_ctrl");
        expect_z(INTC_PEND_ADDR, 1'b0, "rst_z");
        expect_addr(INTC_MASK_ADDR, 1'b1, "addr_hit");
        expect_addr(UNMAPPED, 1'b0, "addr_miss");

        // Timer source, exact latency
        bus_write(INTC_MASK_ADDR, 64'h01);
        bus_write(INTC_CTRL_ADDR, 64'h1);
        repeat (4) tick();
        irq_src = 8'h01;
        expect_irq(1'b0, 0, "s1_pre");
        irq_src = 8'h00;
        idle(L, "s1_sync");
        bus_read(INTC_PEND_ADDR, 64'h01, "s1_pend");
        expect_irq(1'b1, 0, "s1_req");
        pulse_eret();
        expect_irq(1'b1, 0, "s1_eret_ignored");
        pulse_taken();
        expect_irq(1'b0, 0, "s1_service");
        bus_read(INTC_CTRL_ADDR, 64'h3, "s1_ctrl_insvc");
        bus_write(INTC_PEND_ADDR, 64'h01);
        bus_read(INTC_PEND_ADDR, 64'h00, "s1_w1c");
        pulse_eret();
        idle(3, "s1_done");
        bus_read(INTC_CTRL_ADDR, 64'h1, "s1_ctrl_idle");

        // Simultaneous sources 3 and 5
        bus_write(INTC_MASK_ADDR, 64'hFF);
        irq_src = 8'h28;
        expect_irq(1'b0, 0, "s2_pre");
        idle(L, "s2_sync");
        bus_read(INTC_PEND_ADDR, 64'h28, "s2_pend");
        expect_irq(1'b1, 3, "s2_cause3");
        pulse_taken();
        bus_write(INTC_PEND_ADDR, 64'h08);
        pulse_eret();
        expect_irq(1'b0, 0, "s2_gap");
        expect_irq(1'b1, 5, "s2_cause5");
        pulse_taken();
        bus_write(INTC_PEND_ADDR, 64'h20);
        pulse_eret();
        irq_src = 8'h00;
        idle(2 + L, "s2_done");

        // Masked pending, then unmask
        bus_write(INTC_MASK_ADDR, 64'h00);
        irq_src = 8'h04;
        expect_irq(1'b0, 0, "s3_pre");
        idle(L, "s3_sync");
        bus_read(INTC_PEND_ADDR, 64'h04, "s3_pend");
        pulse_taken();
        idle(2, "s3_noreq");
        bus_write(INTC_MASK_ADDR, 64'h04);
        expect_irq(1'b0, 0, "s3_wait");
        expect_irq(1'b1, 2, "s3_cause2");
        pulse_taken();
        bus_read(INTC_CTRL_ADDR, 64'h3, "s3_ctrl_insvc");
        bus_write(INTC_PEND_ADDR, 64'h04);
        pulse_eret();
        irq_src = 8'h00;
        idle(2 + L, "s3_done");

        // Held level sets once; re-edge; set beats clear
        bus_write(INTC_CTRL_ADDR, 64'h0);
        irq_src = 8'h02;
        tick();
        repeat (L) tick();
        bus_read(INTC_PEND_ADDR, 64'h02, "s4_pend");
        repeat (20) tick();
        bus_read(INTC_PEND_ADDR, 64'h02, "s4_held");
        bus_write(INTC_PEND_ADDR, 64'h02);
        repeat (5) tick();
        bus_read(INTC_PEND_ADDR, 64'h00, "s4_no_reset");
        irq_src = 8'h00;
        repeat (3 + L) tick();
        irq_src = 8'h02;
        tick();
        repeat (L) tick();
        bus_read(INTC_PEND_ADDR, 64'h02, "s4_reedge");
        bus_write(INTC_PEND_ADDR, 64'h02);
        bus_read(INTC_PEND_ADDR, 64'h00, "s4_cleared");
        irq_src = 8'h00;
        repeat (3 + L) tick();
        irq_src = 8'h02;
        repeat (L) tick();
        bus_write(INTC_PEND_ADDR, 64'h02);
        bus_read(INTC_PEND_ADDR, 64'h02, "s4_set_wins");
        bus_write(INTC_PEND_ADDR, 64'h02);
        irq_src = 8'h00;
        repeat (3 + L) tick();

        // No retraction while in REQ
        bus_write(INTC_MASK_ADDR, 64'h10);
        bus_write(INTC_CTRL_ADDR, 64'h1);
        irq_src = 8'h10;
        tick();
        repeat (L) tick();
        bus_read(INTC_PEND_ADDR, 64'h10, "s5_pend");
        expect_irq(1'b1, 4, "s5_req");
        bus_write(INTC_MASK_ADDR, 64'h00);
        bus_write(INTC_PEND_ADDR, 64'h10);
        expect_irq(1'b1, 4, "s5_hold1");
        bus_read(INTC_PEND_ADDR, 64'h00, "s5_cleared");
        expect_irq(1'b1, 4, "s5_hold2");
        pulse_taken();
        expect_irq(1'b0, 0, "s5_service");
        bus_read(INTC_CTRL_ADDR, 64'h3, "s5_insvc");

        // Reset during SERVICE
        bus_write(INTC_MASK_ADDR, 64'h80);
        irq_src = 8'h90;
        tick();
        repeat (L) tick();
        bus_read(INTC_PEND_ADDR, 64'h80, "s6_pend_pre");
        irq_src = 8'h00;
        reset = 1'b1;
        expect_irq(1'b0, 0, "s6_rst_irq");
        bus_read(INTC_PEND_ADDR, 64'h00, "s6_rst_pend_in");
        reset = 1'b0;
        tick();
        bus_read(INTC_PEND_ADDR, 64'h00, "s6_pend");
        bus_read(INTC_MASK_ADDR, 64'h00, "s6_mask");
        bus_read(INTC_CTRL_ADDR, 64'h00, "s6_ctrl");
        expect_z(INTC_CTRL_ADDR, 1'b0, "s6_z_noread");
        expect_z(UNMAPPED, 1'b1, "s6_z_unmapped");

        // Back to normal operation after reset
        bus_write(INTC_MASK_ADDR, 64'h01);
        bus_write(INTC_CTRL_ADDR, 64'h1);
        irq_src = 8'h01;
        expect_irq(1'b0, 0, "s7_pre");
        idle(L, "s7_sync");
        bus_read(INTC_PEND_ADDR, 64'h01, "s7_pend");
        expect_irq(1'b1, 0, "s7_req");

        repeat (2) tick();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_drain: got %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
